fwd_hazard_unit: RTL and testbench

Forwarding and load-use hazard controller for the pipelined datapath. It tracks the destination register and control bits of the instructions in the EX, MEM and WB stages. Each cycle it drives the 2-bit select lines of the two 32-bit 3:1 operand multiplexers at the ALU inputs. It also raises a one-cycle stall when an instruction in ID needs a load result that is not yet available.

---
 rtl/fwd_hazard_unit.sv | 119 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use stall control
// for the EX/MEM/WB pipeline of the integer datapath.
module fwd_hazard_unit #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_uses_rt,
  input  logic              flush,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              uses_rt;
  } ex_rec_t;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } mem_rec_t;

  // WB never needs mem_read: a load there forwards like any result
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic              reg_write;
  } wb_rec_t;

  ex_rec_t          ex_q, ex_d;
  mem_rec_t         mem_q, mem_d;
  wb_rec_t          wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_hit;

  function automatic logic [1:0] pick(
    input logic [ADDR_W-1:0] s,
    input mem_rec_t          m,
    input wb_rec_t           w
  );
    logic m_hit;
    logic w_hit;
    m_hit = m.reg_write && (m.rd != '0)
         && (m.rd == s) && !m.mem_read;
    w_hit = w.reg_write && (w.rd != '0)
         && (w.rd == s);
    if (m_hit)
      pick = 2'b01;
    else if (w_hit)
      pick = 2'b10;
    else
      pick = 2'b00;
  endfunction

  always_comb begin
    ld_hit = ex_q.mem_read && ex_q.reg_write
          && (ex_q.rd != '0)
          && ((ex_q.rd == id_rs)
          || (id_uses_rt && (ex_q.rd == id_rt)));
    stall  = ld_hit && !flush;
  end

  always_comb begin
    fwd_sel_a = pick(ex_q.rs, mem_q, wb_q);
    fwd_sel_b = 2'b00;
    if (ex_q.uses_rt)
      fwd_sel_b = pick(ex_q.rt, mem_q, wb_q);
  end

  always_comb begin
    ex_d = '0;
    if (!stall && !flush) begin
      ex_d.rs        = id_rs;
      ex_d.rt        = id_rt;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      ex_d.uses_rt   = id_uses_rt;
    end
    mem_d.rd        = ex_q.rd;
    mem_d.reg_write = ex_q.reg_write;
    mem_d.mem_read  = ex_q.mem_read;
    wb_d.rd         = mem_q.rd;
    wb_d.reg_write  = mem_q.reg_write;
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: stage-history model plus
// directed instruction sequences with literal checks.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic [4:0]  id_rd = '0;
  logic        id_reg_write = 1'b0;
  logic        id_mem_read = 1'b0;
  logic        id_uses_rt = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic        stall;
  logic [15:0] stall_count;
  logic [1:0]  s_sel_a, s_sel_b;
  logic        s_stall;
  logic [1:0]  s_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read),
    .id_uses_rt(id_uses_rt), .flush(flush),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall(stall), .stall_count(stall_count)
  );

  fwd_hazard_unit #(.ADDR_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read),
    .id_uses_rt(id_uses_rt), .flush(flush),
    .fwd_sel_a(s_sel_a), .fwd_sel_b(s_sel_b),
    .stall(s_stall), .stall_count(s_count)
  );

  // model: pl[0]=EX, pl[1]=MEM, pl[2]=WB
  typedef struct packed {
    logic [4:0] rs, rt, rd;
    logic wr, ld, ut;
  } ins_t;

  ins_t pl [3];
  int   m_cnt = 0;
  int   m_cnt2 = 0;
  bit   hold = 1'b0;

  initial begin
    for (int k = 0; k < 3; k++) pl[k] = '0;
  end

  task automatic chk(input string nm, input int got,
                     input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, got, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    ins_t e;
    e = pl[0];
    if (flush || !e.ld || !e.wr || e.rd == 0) return 1'b0;
    return (e.rd == id_rs) || (id_uses_rt && e.rd == id_rt);
  endfunction

  // newest non-load producer in MEM, else any producer in WB
  function automatic logic [1:0] m_sel(input logic [4:0] s);
    for (int k = 1; k < 3; k++) begin
      if (pl[k].wr && pl[k].rd != 0 && pl[k].rd == s
          && !(k == 1 && pl[k].ld))
        return (k == 1) ? 2'b01 : 2'b10;
    end
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) pl[k] = '0;
      m_cnt = 0;
      m_cnt2 = 0;
      hold = 1'b0;
    end else begin
      hold = m_stall();
      if (hold) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
      end
      pl[2] = pl[1];
      pl[1] = pl[0];
      if (hold || flush)
        pl[0] = '0;
      else
        pl[0] = {id_rs, id_rt, id_rd, id_reg_write,
                 id_mem_read, id_uses_rt};
    end
  end

  always @(negedge clk) begin : cmp
    logic [1:0] ea, eb;
    ea = m_sel(pl[0].rs);
    eb = pl[0].ut ? m_sel(pl[0].rt) : 2'b00;
    chk("cyc_sel_a", fwd_sel_a, ea);
    chk("cyc_sel_b", fwd_sel_b, eb);
    chk("cyc_stall", stall, m_stall());
    chk("cyc_count", stall_count, m_cnt);
    chk("cyc_sat_sel_a", s_sel_a, ea);
    chk("cyc_sat_stall", s_stall, m_stall());
    chk("cyc_sat_count", s_count, m_cnt2);
  end

  task automatic put(input logic [4:0] rs, rt, rd,
                     input bit wr, ld, ut, fl);
    @(posedge clk);
    #1;
    while (hold) begin
      @(posedge clk);
      #1;
    end
    id_rs = rs;
    id_rt = rt;
    id_rd = rd;
    id_reg_write = wr;
    id_mem_read = ld;
    id_uses_rt = ut;
    flush = fl;
  endtask

  task automatic nop();
    put(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    repeat (3) nop();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int exp_s [4];
    exp_s = '{2, 3, 3, 3};

    // reset held with random traffic
    repeat (4) begin
      put(5'($urandom), 5'($urandom), 5'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom));
      @(negedge clk);
      chk("rst_sel_a", fwd_sel_a, 0);
      chk("rst_sel_b", fwd_sel_b, 0);
      chk("rst_stall", stall, 0);
      chk("rst_count", stall_count, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    drain();

    // EX/MEM forward: add r3 ; sub r3,r4
    put(1, 2, 3, 1, 0, 1, 0);
    put(3, 4, 6, 1, 0, 1, 0);
    nop();
    @(negedge clk);
    chk("exmem_sel_a", fwd_sel_a, 1);
    chk("exmem_sel_b", fwd_sel_b, 0);
    chk("model_exmem", m_sel(pl[0].rs), 1);
    drain();

    // MEM/WB forward: add r5 ; nop ; use r5
    put(1, 2, 5, 1, 0, 1, 0);
    nop();
    put(5, 0, 8, 1, 0, 0, 0);
    nop();
    @(negedge clk);
    chk("memwb_sel_a", fwd_sel_a, 2);
    chk("model_memwb", m_sel(pl[0].rs), 2);
    drain();

    // priority: add r5 ; or r5 ; use r5
    put(1, 2, 5, 1, 0, 1, 0);
    put(1, 0, 5, 1, 0, 0, 0);
    put(5, 0, 8, 1, 0, 0, 0);
    nop();
    @(negedge clk);
    chk("prio_sel_a", fwd_sel_a, 1);
    drain();

    // load-use: lw r7 ; use rt=r7
    put(1, 0, 7, 1, 1, 0, 0);
    put(0, 7, 9, 1, 0, 1, 0);
    @(negedge clk);
    chk("lu_stall", stall, 1);
    chk("lu_count0", stall_count, 0);
    chk("model_lu_stall", m_stall(), 1);
    nop();
    @(negedge clk);
    chk("lu_stall_gone", stall, 0);
    chk("lu_count1", stall_count, 1);
    chk("lu_sel_b", fwd_sel_b, 2);
    chk("lu_sel_a", fwd_sel_a, 0);
    drain();

    // load to r0 never stalls
    put(1, 0, 0, 1, 1, 0, 0);
    put(0, 0, 9, 1, 0, 1, 0);
    @(negedge clk);
    chk("r0_stall", stall, 0);
    nop();
    @(negedge clk);
    chk("r0_sel_b", fwd_sel_b, 0);
    chk("r0_count", stall_count, 1);
    drain();

    // flush beats stall; flushed writer r11 must not reach EX
    put(1, 0, 2, 1, 1, 0, 0);
    put(2, 0, 11, 1, 0, 0, 1);
    @(negedge clk);
    chk("fl_stall", stall, 0);
    put(11, 0, 12, 1, 0, 0, 0);
    @(negedge clk);
    chk("fl_count", stall_count, 1);
    nop();
    @(negedge clk);
    chk("fl_bubble_sel_a", fwd_sel_a, 0);
    drain();

    // saturation of the 2-bit counter
    for (int i = 0; i < 4; i++) begin
      put(1, 0, 7, 1, 1, 0, 0);
      put(0, 7, 9, 1, 0, 1, 0);
      nop();
      @(negedge clk);
      chk("sat_count", s_count, exp_s[i]);
      chk("wide_count", stall_count, i + 2);
    end
    drain();

    // back-to-back loads each stall once
    put(1, 0, 7, 1, 1, 0, 0);
    put(7, 0, 8, 1, 1, 0, 0);
    put(8, 0, 9, 1, 0, 0, 0);
    nop();
    @(negedge clk);
    chk("b2b_sel_a", fwd_sel_a, 2);
    chk("b2b_count", stall_count, 7);
    drain();

    // async reset mid-stream with a stall and a forward live
    put(0, 0, 1, 1, 0, 0, 0);
    put(1, 0, 7, 1, 1, 0, 0);
    put(0, 7, 9, 1, 0, 1, 0);
    @(negedge clk);
    chk("pre_rst_stall", stall, 1);
    chk("pre_rst_sel_a", fwd_sel_a, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_stall", stall, 0);
    chk("arst_sel_a", fwd_sel_a, 0);
    chk("arst_sel_b", fwd_sel_b, 0);
    chk("arst_count", stall_count, 0);
    chk("arst_sat_count", s_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
